counter_seq_ctrl: RTL
=====================

COUNTER_SEQ_CTRL -- requirements
Module: counter_seq_ctrl

Interface
REQ-001 Parameter WIDTH, default 3: counter width in bits.
REQ-002 Parameter WRAPW, default 8: width of the wrap-count request and status.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  run request, sampled in IDLE only.
REQ-006 pause  input  1  level: hold the count while high.
REQ-007 abort  input  1  level: terminate the run and return to IDLE.
REQ-008 mod_val  input  WIDTH  modulus; count runs 0..mod_val-1; latched at start.
REQ-009 wraps  input  WRAPW  number of full wraps per run; latched at start.
REQ-010 dout  output  WIDTH  current count, registered.
REQ-011 wrap_cnt  output  WRAPW  wraps completed in the current run, registered.
REQ-012 busy  output  1  high in RUN or HOLD.
REQ-013 wrap  output  1  one-cycle pulse, high in the cycle after dout returns to its start value.
REQ-014 done  output  1  one-cycle pulse, high while in DONE.
REQ-015 err  output  1  one-cycle pulse on a rejected start.

Function
REQ-016 The FSM SHALL use four states: IDLE, RUN, HOLD and DONE.
REQ-017 In IDLE, start with mod_val>=2 and wraps!=0 SHALL latch mod_val and wraps, clear dout and wrap_cnt, and enter RUN on the next edge.
REQ-018 In IDLE, start with mod_val<2 or wraps==0 SHALL pulse err for 1 cycle and remain in IDLE.
REQ-019 start SHALL be ignored outside IDLE; latched values SHALL NOT change mid-run.
REQ-020 RUN priority SHALL be: abort > pause > count.
REQ-021 In RUN with no abort or pause, dout SHALL increment by 1 each cycle; at dout==mod-1 it SHALL wrap to 0, pulse wrap and increment wrap_cnt.
REQ-022 When the incremented wrap_cnt equals the latched wraps, the FSM SHALL enter DONE on that same edge.
REQ-023 pause in RUN SHALL enter HOLD with dout frozen.
REQ-024 In HOLD, pause deasserting SHALL return to RUN with no increment on that edge.
REQ-025 abort in RUN or HOLD SHALL enter IDLE and clear dout to 0; wrap_cnt SHALL keep its value.
REQ-026 DONE SHALL last exactly 1 cycle with done=1 and dout=0, then enter IDLE; wrap_cnt SHALL hold the final count until the next accepted start.
REQ-027 Arithmetic SHALL be unsigned with no overflow; mod_val = 2^WIDTH-1 SHALL be valid.
REQ-028 Latency from start to the first increment SHALL be 2 edges: one edge to enter RUN, then the first count.

Reset
REQ-029 reset SHALL force IDLE asynchronously, overriding any state including mid-run and DONE.
REQ-030 During and after reset, dout=0, wrap_cnt=0, busy=0, wrap=0, done=0 and err=0.

Configuration
REQ-031 With COUNTER_SEQ_CTRL_DOWN_EN defined, an input dir (1 bit, latched at start) SHALL exist; dir=1 SHALL start dout at mod-1, decrement, and wrap from 0 to mod-1; all other rules SHALL be unchanged.
REQ-032 Without COUNTER_SEQ_CTRL_DOWN_EN, the dir port SHALL be absent and counting SHALL be up-only.

Verification
REQ-033 mod_val=6, wraps=2, start pulse: dout sequence 0..5,0..5; wrap pulses twice; done after 12 counts; wrap_cnt=2; busy low afterwards.
REQ-034 mod_val=1 or wraps=0 with start: err pulses once; busy stays 0; dout stays 0.
REQ-035 mod_val=6, pause high for 3 cycles at dout=3: dout holds 3 for 3 cycles, then continues with 4 on the second edge after pause falls.
REQ-036 abort at dout=4, wrap_cnt=1: the next cycle is IDLE with dout=0 and wrap_cnt=1; no done; start ignored mid-run.
REQ-037 reset asserted mid-run (dout=2): all outputs are 0 immediately without a clock edge; a subsequent start runs normally.
REQ-038 With DOWN_EN defined, dir=1, mod_val=5, wraps=1: dout sequence 4,3,2,1,0, then wrap and done.

Source files
------------

// File: rtl/counter_seq_ctrl.sv
// counter_seq_ctrl: run controller for a modulo counter.
//
// A run is requested with start while IDLE. The modulus (mod_val) and the
// number of full wraps per run (wraps) are captured at that moment. dout then
// walks through 0..mod-1 once per wrap until the requested number of wraps is
// reached. After that the block spends one cycle in DONE and returns to IDLE.
// pause freezes the count (HOLD) and abort terminates the run.
//
// Optional feature: define COUNTER_SEQ_CTRL_DOWN_EN to add a dir input that
// is captured at start. With dir=1 the count starts at mod-1 and runs down to
// 0 before wrapping. Without the macro the dir port does not exist and the
// block counts up only.
module counter_seq_ctrl #(
  parameter int WIDTH = 3,
  parameter int WRAPW = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             pause,
  input  logic             abort,
  input  logic [WIDTH-1:0] mod_val,
  input  logic [WRAPW-1:0] wraps,
`ifdef COUNTER_SEQ_CTRL_DOWN_EN
  input  logic             dir,
`endif
  output logic [WIDTH-1:0] dout,
  output logic [WRAPW-1:0] wrap_cnt,
  output logic             busy,
  output logic             wrap,
  output logic             done,
  output logic             err
);

  // FSM encoding
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  // State and run configuration captured at start
  logic [1:0]       state_q,    state_d;
  logic [WIDTH-1:0] mod_q,      mod_d;
  logic [WRAPW-1:0] wraps_q,    wraps_d;
  logic [WIDTH-1:0] dout_q,     dout_d;
  logic [WRAPW-1:0] wrap_cnt_q, wrap_cnt_d;
  logic             wrap_q,     wrap_d;
  logic             err_q,      err_d;

  // Direction of the captured run, and direction requested at start
  logic             count_down;
  logic             start_down;

`ifdef COUNTER_SEQ_CTRL_DOWN_EN
  logic             dir_q, dir_d;

  assign count_down = dir_q;
  assign start_down = dir;
`else
  assign count_down = 1'b0;
  assign start_down = 1'b0;
`endif

  // Helper terms shared by the next-state logic
  logic             start_ok;
  logic [WIDTH-1:0] start_val;
  logic [WIDTH-1:0] last_val;
  logic [WIDTH-1:0] reload_val;
  logic [WIDTH-1:0] step_val;
  logic             at_end;
  logic [WRAPW-1:0] wrap_cnt_inc;
  logic             run_complete;

  // Decode a start request, the wrap point, and the next count value
  always_comb begin
    // A modulus below 2 or a zero wrap request cannot form a run
    start_ok     = (mod_val > WIDTH'(1)) && (wraps != '0);
    start_val    = start_down ? (mod_val - WIDTH'(1)) : '0;

    // Count value that triggers a wrap, and the value the count reloads to
    last_val     = count_down ? '0 : (mod_q - WIDTH'(1));
    reload_val   = count_down ? (mod_q - WIDTH'(1)) : '0;
    step_val     = count_down ? (dout_q - WIDTH'(1)) : (dout_q + WIDTH'(1));
    at_end       = (dout_q == last_val);

    // wrap_cnt_q < wraps_q during a run, so this increment never overflows
    wrap_cnt_inc = wrap_cnt_q + WRAPW'(1);
    run_complete = (wrap_cnt_inc == wraps_q);
  end

  // Next-state and datapath update for the run FSM
  always_comb begin
    // NOTE: every signal gets a default first, so no path through the case
    // below can leave one unassigned and infer a latch.
    state_d    = state_q;
    mod_d      = mod_q;
    wraps_d    = wraps_q;
    dout_d     = dout_q;
    wrap_cnt_d = wrap_cnt_q;
    wrap_d     = 1'b0;
    err_d      = 1'b0;
`ifdef COUNTER_SEQ_CTRL_DOWN_EN
    dir_d      = dir_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (start_ok) begin
            mod_d      = mod_val;
            wraps_d    = wraps;
            dout_d     = start_val;
            wrap_cnt_d = '0;
`ifdef COUNTER_SEQ_CTRL_DOWN_EN
            dir_d      = dir;
`endif
            state_d    = S_RUN;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      S_RUN: begin
        // abort wins over pause, pause wins over counting
        if (abort) begin
          dout_d  = '0;
          state_d = S_IDLE;
        end else if (pause) begin
          state_d = S_HOLD;
        end else if (at_end) begin
          wrap_d     = 1'b1;
          wrap_cnt_d = wrap_cnt_inc;
          if (run_complete) begin
            dout_d  = '0;
            state_d = S_DONE;
          end else begin
            dout_d = reload_val;
          end
        end else begin
          dout_d = step_val;
        end
      end

      S_HOLD: begin
        // Leaving HOLD costs one edge with no count
        if (abort) begin
          dout_d  = '0;
          state_d = S_IDLE;
        end else if (!pause) begin
          state_d = S_RUN;
        end
      end

      S_DONE: begin
        dout_d  = '0;
        state_d = S_IDLE;
      end

      default: begin
        dout_d  = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Register all state; reset returns to IDLE with every output low
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the captured modulus and wrap target are reset as well. They
      // are only read in RUN/HOLD, but a known value keeps simulation free
      // of X and costs nothing on a handful of flops.
      state_q    <= S_IDLE;
      mod_q      <= '0;
      wraps_q    <= '0;
      dout_q     <= '0;
      wrap_cnt_q <= '0;
      wrap_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values
      // from before this edge, independent of statement order.
      state_q    <= state_d;
      mod_q      <= mod_d;
      wraps_q    <= wraps_d;
      dout_q     <= dout_d;
      wrap_cnt_q <= wrap_cnt_d;
      wrap_q     <= wrap_d;
      err_q      <= err_d;
    end
  end

`ifdef COUNTER_SEQ_CTRL_DOWN_EN
  // Captured count direction for the current run
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dir_q <= 1'b0;
    end else begin
      dir_q <= dir_d;
    end
  end
`endif

  // Outputs come straight from flops or from a decode of the state register
  assign dout     = dout_q;
  assign wrap_cnt = wrap_cnt_q;
  assign wrap     = wrap_q;
  assign err      = err_q;
  assign busy     = (state_q == S_RUN) || (state_q == S_HOLD);
  assign done     = (state_q == S_DONE);

endmodule
